// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite write path and the frame-buffer readers.
package sprite_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} blit_state_t;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    localparam int unsigned FB_W_DEF = 640;
    localparam int unsigned FB_H_DEF = 480;

    function automatic logic skip_pixel(input logic [3:0] idx, input logic transparent_en);
        return transparent_en && (idx == TRANSPARENT_IDX);
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Registered (x,y) -> linear frame-buffer address, with an out-of-bounds flag and data pass-through.
module fb_addr_calc import sprite_pkg::*; #(
    parameter int unsigned FB_W   = FB_W_DEF,
    parameter int unsigned FB_H   = FB_H_DEF,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [ADDR_W:0]   x_i,
    input  logic [ADDR_W:0]   y_i,
    input  logic [3:0]        data_i,
    output logic              valid_o,
    output logic              oob_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        data_o
);

    localparam logic [ADDR_W:0] FbW = (ADDR_W + 1)'(FB_W);
    localparam logic [ADDR_W:0] FbH = (ADDR_W + 1)'(FB_H);

    logic              oob_d;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        oob_d  = (x_i >= FbW) || (y_i >= FbH);
        // Product is formed at ADDR_W+1 bits, then truncated.
        addr_d = ADDR_W'(y_i * FbW + x_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            oob_o   <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                oob_o  <= oob_d;
                addr_o <= addr_d;
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: writes a raster-order stream of palette indices into the frame buffer at (X,Y).
// Define BLIT_TRANSPARENT_EN to drop writes of index TRANSPARENT_IDX.
module sprite_blitter import sprite_pkg::*; #(
    parameter int unsigned SPR_W  = 100,
    parameter int unsigned SPR_H  = 100,
    parameter int unsigned FB_W   = FB_W_DEF,
    parameter int unsigned FB_H   = FB_H_DEF,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [9:0]        X,
    input  logic [9:0]        Y,
    output logic              busy,
    output logic              done,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [3:0]        pix_index,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [3:0]        fb_din
);

`ifdef BLIT_TRANSPARENT_EN
    localparam logic TrEn = 1'b1;
`else
    localparam logic TrEn = 1'b0;
`endif

    localparam int unsigned ColW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RowW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(SPR_W - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(SPR_H - 1);

    blit_state_t     state_q;
    logic [9:0]      x0_q, y0_q;
    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;

    logic            accept, last_col, last_row, wr_req, wr_vld, wr_oob;
    logic [ADDR_W:0] sx, sy;

    always_comb begin
        pix_ready = (state_q == RUN);
        busy      = (state_q == RUN) || (state_q == FLUSH);
        done      = (state_q == DONE);
        accept    = pix_ready && pix_valid;
        last_col  = (col_q == ColLast);
        last_row  = (row_q == RowLast);
        wr_req    = accept && !skip_pixel(pix_index, TrEn);
        sx        = (ADDR_W + 1)'(x0_q) + (ADDR_W + 1)'(col_q);
        sy        = (ADDR_W + 1)'(y0_q) + (ADDR_W + 1)'(row_q);
        // Clipped pixels still advance the counters but never strobe the RAM.
        fb_we     = wr_vld && !wr_oob;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x0_q    <= X;
                        y0_q    <= Y;
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                state_q <= FLUSH;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                FLUSH:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    fb_addr_calc #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .valid_i (wr_req),
        .x_i     (sx),
        .y_i     (sy),
        .data_i  (pix_index),
        .valid_o (wr_vld),
        .oob_o   (wr_oob),
        .addr_o  (fb_addr),
        .data_o  (fb_din)
    );

endmodule
